// File: rtl/exe_iter_div_pkg.sv
// exe_iter_div_pkg: shared types and constants for the iterative divide unit
package exe_iter_div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;
  localparam int DIV_W32 = 32;
endpackage

// File: rtl/exe_iter_div_if.sv
// exe_iter_div_if: request/result bundle between the execution stage and the divider
//   requester -> divider: kill_i, request_i, op_32_i, signed_i, dvnd_i, dvsr_i, tag_i
//   divider -> requester: quo_o, rmd_o, tag_o, stall_o, done_tick_o
interface exe_iter_div_if #(
  parameter int XLEN = 64,
  parameter int TAG_W = 5
);
  logic kill_i;
  logic request_i;
  logic op_32_i;
  logic signed_i;
  logic [XLEN-1:0] dvnd_i;
  logic [XLEN-1:0] dvsr_i;
  logic [TAG_W-1:0] tag_i;
  logic [XLEN-1:0] quo_o;
  logic [XLEN-1:0] rmd_o;
  logic [TAG_W-1:0] tag_o;
  logic stall_o;
  logic done_tick_o;
  modport master (
    output kill_i, request_i, op_32_i, signed_i, dvnd_i, dvsr_i, tag_i,
    input  quo_o, rmd_o, tag_o, stall_o, done_tick_o
  );
  modport slave (
    input  kill_i, request_i, op_32_i, signed_i, dvnd_i, dvsr_i, tag_i,
    output quo_o, rmd_o, tag_o, stall_o, done_tick_o
  );
endinterface

// File: rtl/exe_div_step.sv
// exe_div_step: one combinational restoring shift-subtract division step
//   rem_i/bit_i: partial remainder and next dividend bit, dvsr_i: divisor magnitude
//   rem_o: next partial remainder, q_o: produced quotient bit
module exe_div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic            bit_i,
  input  logic [XLEN-1:0] dvsr_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_o
);
  logic [XLEN:0] sh;
  logic [XLEN:0] diff;
  // rem_i < dvsr_i, so the shifted value needs one extra bit and the borrow sits in the top bit
  assign sh = {rem_i, bit_i};
  assign diff = sh - {1'b0, dvsr_i};
  assign q_o = ~diff[XLEN];
  assign rem_o = q_o ? diff[XLEN-1:0] : sh[XLEN-1:0];
endmodule

// File: rtl/exe_iter_div.sv
// exe_iter_div: multi-cycle signed/unsigned integer divider with word mode, early-out and kill
//   clk_i, rst_i: clock and synchronous active-high reset
//   bus (slave): operands, op flags, tag and kill in; quotient, remainder, tag, stall, done out
module exe_iter_div
  import exe_iter_div_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int TAG_W = 5
) (
  input logic clk_i,
  input logic rst_i,
  exe_iter_div_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam int SH = XLEN - DIV_W32;
  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = ~XLEN'(32'h7fff_ffff);
  div_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] dq_q, dq_d, rem_q, rem_d, dvsr_q, dvsr_d;
  logic [XLEN-1:0] quo_q, quo_d, rmd_q, rmd_d;
  logic [TAG_W-1:0] tagw_q, tagw_d, tag_q, tag_d;
  logic negq_q, negq_d, negr_q, negr_d, w32_q, w32_d;
  logic [XLEN-1:0] ext_a, ext_b, mag_a, mag_b, step_rem;
  logic neg_a, neg_b, div0, ovf, accept, step_q;
  // Word mode keeps the low 32 bits, extended by sign (s) or zero; full width passes through
  function automatic logic [XLEN-1:0] wext(input logic [XLEN-1:0] x, input logic w, input logic s);
    logic signed [XLEN-1:0] t;
    t = x << SH;
    t = s ? t >>> SH : t >> SH;
    return w ? t : x;
  endfunction
  assign ext_a = wext(bus.dvnd_i, bus.op_32_i, bus.signed_i);
  assign ext_b = wext(bus.dvsr_i, bus.op_32_i, bus.signed_i);
  assign neg_a = bus.signed_i & ext_a[XLEN-1];
  assign neg_b = bus.signed_i & ext_b[XLEN-1];
  assign mag_a = neg_a ? -ext_a : ext_a;
  assign mag_b = neg_b ? -ext_b : ext_b;
  assign div0 = ext_b == '0;
  assign ovf = bus.signed_i & (ext_b == '1) & (ext_a == (bus.op_32_i ? MIN_W : MIN_X));
  assign accept = bus.request_i & ~bus.kill_i & (state_q == IDLE | state_q == DONE);
  exe_div_step #(.XLEN(XLEN)) u_step (
    .rem_i (rem_q),
    .bit_i (dq_q[XLEN-1]),
    .dvsr_i(dvsr_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    dq_d = dq_q;
    rem_d = rem_q;
    dvsr_d = dvsr_q;
    negq_d = negq_q;
    negr_d = negr_q;
    w32_d = w32_q;
    tagw_d = tagw_q;
    quo_d = quo_q;
    rmd_d = rmd_q;
    tag_d = tag_q;
    case (state_q)
      // dq_q shifts dividend bits out of the top while quotient bits enter at the bottom
      CALC: begin
        dq_d = {dq_q[XLEN-2:0], step_q};
        rem_d = step_rem;
        cnt_d = cnt_q - 1'b1;
        state_d = cnt_q == '0 ? FIX : CALC;
      end
      FIX: begin
        quo_d = wext(negq_q ? -dq_q : dq_q, w32_q, 1'b1);
        rmd_d = wext(negr_q ? -rem_q : rem_q, w32_q, 1'b1);
        tag_d = tagw_q;
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
        if (accept) begin
          // Word dividends are left-aligned so the step always consumes from the top bit
          dq_d = bus.op_32_i ? mag_a << SH : mag_a;
          rem_d = '0;
          dvsr_d = mag_b;
          negq_d = neg_a ^ neg_b;
          negr_d = neg_a;
          w32_d = bus.op_32_i;
          tagw_d = bus.tag_i;
          cnt_d = CW'(bus.op_32_i ? DIV_W32 - 1 : XLEN - 1);
          state_d = (div0 | ovf) ? DONE : CALC;
          if (div0 | ovf) begin
            quo_d = div0 ? '1 : ext_a;
            rmd_d = div0 ? wext(bus.dvnd_i, bus.op_32_i, 1'b1) : '0;
            tag_d = bus.tag_i;
          end
        end
      end
    endcase
    if (bus.kill_i) begin
      state_d = IDLE;
      quo_d = quo_q;
      rmd_d = rmd_q;
      tag_d = tag_q;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      dq_q <= '0;
      rem_q <= '0;
      dvsr_q <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      w32_q <= 1'b0;
      tagw_q <= '0;
      quo_q <= '0;
      rmd_q <= '0;
      tag_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dq_q <= dq_d;
      rem_q <= rem_d;
      dvsr_q <= dvsr_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      w32_q <= w32_d;
      tagw_q <= tagw_d;
      quo_q <= quo_d;
      rmd_q <= rmd_d;
      tag_q <= tag_d;
    end
  end
  assign bus.quo_o = quo_q;
  assign bus.rmd_o = rmd_q;
  assign bus.tag_o = tag_q;
  assign bus.done_tick_o = state_q == DONE;
  assign bus.stall_o = accept | state_q == CALC | state_q == FIX;
endmodule

// File: tb/tb_exe_iter_div.sv
// tb_exe_iter_div: directed self-checking bench for exe_iter_div
module tb_exe_iter_div;
  localparam int XLEN = 64;
  localparam int TAG_W = 5;
  typedef struct {
    logic w;
    logic s;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] q;
    logic [63:0] r;
    int lat;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  exe_iter_div_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();
  exe_iter_div #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic issue(input logic w, input logic s, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] t);
    bus.op_32_i = w;
    bus.signed_i = s;
    bus.dvnd_i = a;
    bus.dvsr_i = b;
    bus.tag_i = t;
    bus.request_i = 1'b1;
  endtask

  task automatic wait_done(input int limit, output int lat, output int stalls);
    lat = -1;
    stalls = 0;
    for (int c = 1; c <= limit; c++) begin
      @(posedge clk);
      #1;
      bus.request_i = 1'b0;
      #1;
      if (bus.done_tick_o) begin
        lat = c;
        break;
      end
      if (bus.stall_o) stalls++;
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++; if (bus.quo_o !== 64'd0) begin errors++; $display("FAIL reset_quo: got %h want 0", bus.quo_o); end
    checks++; if (bus.rmd_o !== 64'd0) begin errors++; $display("FAIL reset_rmd: got %h want 0", bus.rmd_o); end
    checks++; if (bus.tag_o !== 5'd0) begin errors++; $display("FAIL reset_tag: got %0d want 0", bus.tag_o); end
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.stall_o); end
    checks++; if (bus.done_tick_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done_tick_o); end
  endtask

  task automatic test_vectors(input string nm, input vec_t v[$]);
    int lat, st;
    foreach (v[i]) begin
      @(posedge clk);
      #1;
      issue(v[i].w, v[i].s, v[i].a, v[i].b, 5'(i + 1));
      #1;
      checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL %s[%0d]_stall_accept: got %b want 1", nm, i, bus.stall_o); end
      wait_done(80, lat, st);
      checks++; if (lat !== v[i].lat) begin errors++; $display("FAIL %s[%0d]_latency: got %0d want %0d", nm, i, lat, v[i].lat); end
      checks++; if (bus.quo_o !== v[i].q) begin errors++; $display("FAIL %s[%0d]_quo: got %h want %h", nm, i, bus.quo_o, v[i].q); end
      checks++; if (bus.rmd_o !== v[i].r) begin errors++; $display("FAIL %s[%0d]_rmd: got %h want %h", nm, i, bus.rmd_o, v[i].r); end
      checks++; if (bus.tag_o !== 5'(i + 1)) begin errors++; $display("FAIL %s[%0d]_tag: got %0d want %0d", nm, i, bus.tag_o, i + 1); end
      checks++; if (st !== v[i].lat - 1) begin errors++; $display("FAIL %s[%0d]_stall_cycles: got %0d want %0d", nm, i, st, v[i].lat - 1); end
      checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL %s[%0d]_stall_done: got %b want 0", nm, i, bus.stall_o); end
      @(posedge clk);
      #2;
      checks++; if (bus.done_tick_o !== 1'b0) begin errors++; $display("FAIL %s[%0d]_done_pulse: got %b want 0", nm, i, bus.done_tick_o); end
      checks++; if (bus.quo_o !== v[i].q) begin errors++; $display("FAIL %s[%0d]_quo_hold: got %h want %h", nm, i, bus.quo_o, v[i].q); end
    end
  endtask

  task automatic test_normal();
    vec_t v[$];
    v.push_back('{1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 66});
    v.push_back('{1'b0, 1'b1, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 66});
    v.push_back('{1'b0, 1'b1, 64'd100, -64'sd7, -64'sd14, 64'd2, 66});
    v.push_back('{1'b0, 1'b1, -64'sd100, -64'sd7, 64'd14, -64'sd2, 66});
    v.push_back('{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0001, 64'hFFFF_FFFF, 64'd0, 66});
    v.push_back('{1'b0, 1'b0, 64'd5, 64'd9, 64'd0, 64'd5, 66});
    v.push_back('{1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'h8000_0000_0000_0000, 66});
    test_vectors("normal", v);
  endtask

  task automatic test_special();
    vec_t v[$];
    v.push_back('{1'b0, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1});
    v.push_back('{1'b1, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 64'd0, 1});
    v.push_back('{1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd0, 1});
    v.push_back('{1'b1, 1'b1, 64'hABCD_0000_0000_0010, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 1});
    test_vectors("special", v);
  endtask

  task automatic test_word();
    vec_t v[$];
    v.push_back('{1'b1, 1'b0, 64'hFFFF_FFFF, 64'd2, 64'h7FFF_FFFF, 64'd1, 34});
    v.push_back('{1'b1, 1'b1, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 34});
    v.push_back('{1'b1, 1'b0, 64'h1111_1111_8000_0000, 64'h2222_2222_0000_0001, 64'hFFFF_FFFF_8000_0000, 64'd0, 34});
    v.push_back('{1'b1, 1'b1, 64'h8000_0000, 64'd2, 64'hFFFF_FFFF_C000_0000, 64'd0, 34});
    test_vectors("word", v);
  endtask

  task automatic test_kill();
    int lat, st, dones;
    @(posedge clk);
    #1;
    issue(1'b0, 1'b0, 64'h55, 64'd0, 5'd12);
    wait_done(5, lat, st);
    checks++; if (lat !== 1) begin errors++; $display("FAIL kill_setup_latency: got %0d want 1", lat); end
    @(posedge clk);
    #1;
    issue(1'b0, 1'b0, 64'd100, 64'd7, 5'd13);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      bus.request_i = 1'b0;
    end
    bus.kill_i = 1'b1;
    #1;
    checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL kill_stall_calc: got %b want 1", bus.stall_o); end
    @(posedge clk);
    #1;
    bus.kill_i = 1'b0;
    #1;
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL kill_idle_stall: got %b want 0", bus.stall_o); end
    dones = 0;
    for (int c = 0; c < 80; c++) begin
      if (bus.done_tick_o) dones++;
      @(posedge clk);
      #2;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL kill_no_done: got %0d pulses want 0", dones); end
    checks++; if (bus.quo_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL kill_quo_hold: got %h want all ones", bus.quo_o); end
    checks++; if (bus.rmd_o !== 64'h55) begin errors++; $display("FAIL kill_rmd_hold: got %h want 55", bus.rmd_o); end
    checks++; if (bus.tag_o !== 5'd12) begin errors++; $display("FAIL kill_tag_hold: got %0d want 12", bus.tag_o); end
    @(posedge clk);
    #1;
    issue(1'b0, 1'b0, 64'h66, 64'd0, 5'd14);
    @(posedge clk);
    #1;
    issue(1'b0, 1'b0, 64'd100, 64'd7, 5'd15);
    bus.kill_i = 1'b1;
    #1;
    checks++; if (bus.done_tick_o !== 1'b1) begin errors++; $display("FAIL kill_done_kept: got %b want 1", bus.done_tick_o); end
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL kill_done_stall: got %b want 0", bus.stall_o); end
    checks++; if (bus.tag_o !== 5'd14) begin errors++; $display("FAIL kill_done_tag: got %0d want 14", bus.tag_o); end
    @(posedge clk);
    #1;
    bus.kill_i = 1'b0;
    bus.request_i = 1'b0;
    dones = 0;
    for (int c = 0; c < 80; c++) begin
      #1;
      if (bus.done_tick_o || bus.stall_o) dones++;
      @(posedge clk);
      #1;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL kill_blocked_accept: got %0d busy cycles want 0", dones); end
  endtask

  task automatic test_back_to_back();
    int lat, st;
    @(posedge clk);
    #1;
    issue(1'b0, 1'b0, 64'd100, 64'd7, 5'd3);
    wait_done(80, lat, st);
    checks++; if (lat !== 66) begin errors++; $display("FAIL b2b_first_latency: got %0d want 66", lat); end
    issue(1'b0, 1'b0, 64'd1000, 64'd10, 5'd9);
    #1;
    checks++; if (bus.done_tick_o !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b want 1", bus.done_tick_o); end
    checks++; if (bus.tag_o !== 5'd3) begin errors++; $display("FAIL b2b_first_tag: got %0d want 3", bus.tag_o); end
    checks++; if (bus.quo_o !== 64'd14) begin errors++; $display("FAIL b2b_first_quo: got %h want 14", bus.quo_o); end
    checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL b2b_accept_stall: got %b want 1", bus.stall_o); end
    wait_done(80, lat, st);
    checks++; if (lat !== 66) begin errors++; $display("FAIL b2b_second_latency: got %0d want 66", lat); end
    checks++; if (bus.tag_o !== 5'd9) begin errors++; $display("FAIL b2b_second_tag: got %0d want 9", bus.tag_o); end
    checks++; if (bus.quo_o !== 64'd100) begin errors++; $display("FAIL b2b_second_quo: got %h want 100", bus.quo_o); end
    checks++; if (bus.rmd_o !== 64'd0) begin errors++; $display("FAIL b2b_second_rmd: got %h want 0", bus.rmd_o); end
    issue(1'b0, 1'b0, 64'h77, 64'd0, 5'd4);
    wait_done(5, lat, st);
    checks++; if (lat !== 1) begin errors++; $display("FAIL b2b_special_latency: got %0d want 1", lat); end
    checks++; if (bus.tag_o !== 5'd4) begin errors++; $display("FAIL b2b_special_tag: got %0d want 4", bus.tag_o); end
    checks++; if (bus.rmd_o !== 64'h77) begin errors++; $display("FAIL b2b_special_rmd: got %h want 77", bus.rmd_o); end
  endtask

  task automatic test_reset_mid();
    int dones;
    @(posedge clk);
    #1;
    issue(1'b0, 1'b1, -64'sd7, 64'd2, 5'd21);
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      bus.request_i = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++; if (bus.quo_o !== 64'd0) begin errors++; $display("FAIL rstmid_quo: got %h want 0", bus.quo_o); end
    checks++; if (bus.rmd_o !== 64'd0) begin errors++; $display("FAIL rstmid_rmd: got %h want 0", bus.rmd_o); end
    checks++; if (bus.tag_o !== 5'd0) begin errors++; $display("FAIL rstmid_tag: got %0d want 0", bus.tag_o); end
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL rstmid_stall: got %b want 0", bus.stall_o); end
    dones = 0;
    for (int c = 0; c < 70; c++) begin
      if (bus.done_tick_o) dones++;
      @(posedge clk);
      #2;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses want 0", dones); end
  endtask

  initial begin
    bus.kill_i = 1'b0;
    bus.request_i = 1'b0;
    bus.op_32_i = 1'b0;
    bus.signed_i = 1'b0;
    bus.dvnd_i = '0;
    bus.dvsr_i = '0;
    bus.tag_i = '0;
    repeat (3) @(posedge clk);
    test_reset();
    test_normal();
    test_special();
    test_word();
    test_kill();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
